// File: rtl/tsn_switch_pkg.sv
// Shared constants for the TSN switch datapath: tuser field layout, Ethernet header
// byte offsets and the header-FSM state encoding.
package tsn_switch_pkg;

  localparam int NUM_PORTS = 6;

  localparam int TUSER_LEN_LSB = 0;
  localparam int TUSER_LEN_W   = 16;
  localparam int TUSER_SRC_LSB = 16;
  localparam int TUSER_DST_LSB = 24;
  localparam int TUSER_PORT_W  = 8;
  localparam int TUSER_PCP_LSB = 32;
  localparam int PCP_W         = 3;

  localparam logic [15:0] ETH_TYPE_VLAN = 16'h8100;

  localparam int HDR_DMAC_BYTE  = 0;
  localparam int HDR_SMAC_BYTE  = 6;
  localparam int HDR_ETYPE_BYTE = 12;
  localparam int HDR_TCI_BYTE   = 14;

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_BODY = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

endpackage

// File: rtl/output_port_lookup_six_ports_if.sv
// AXI-Stream bundle used on both sides of the output port lookup stage.
interface output_port_lookup_six_ports_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
) ();

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/output_port_lookup_six_ports_mac_lookup_table.sv
// Static forwarding table: per-entry MAC/ports/valid storage, parallel DMAC compare
// and a lowest-index-wins resolver for a previously captured hit vector.
module mac_lookup_table #(
  parameter int NUM_ENTRIES = 16,
  parameter int NUM_PORTS   = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_wrEn,
  input  logic [$clog2(NUM_ENTRIES)-1:0] i_addr,
  input  logic [47:0]                    i_mac,
  input  logic [NUM_PORTS-1:0]           i_ports,
  input  logic                           i_valid,
  input  logic [47:0]                    i_dmac,
  output logic [NUM_ENTRIES-1:0]         o_hitVec,
  input  logic [NUM_ENTRIES-1:0]         i_hitSel,
  output logic                           o_anyHit,
  output logic [NUM_PORTS-1:0]           o_ports
);

  logic [NUM_ENTRIES-1:0] r_valid;
  logic [47:0]            r_mac   [NUM_ENTRIES];
  logic [NUM_PORTS-1:0]   r_ports [NUM_ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_mac[i]   <= '0;
        r_ports[i] <= '0;
      end
    end else if (i_wrEn) begin
      r_valid[i_addr] <= i_valid;
      r_mac[i_addr]   <= i_mac;
      r_ports[i_addr] <= i_ports;
    end
  end

  always_comb begin
    o_hitVec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      o_hitVec[i] = r_valid[i] & (r_mac[i] == i_dmac);
    end
  end

  // Scan downwards so the lowest-index hit is the last one written.
  always_comb begin
    o_anyHit = |i_hitSel;
    o_ports  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (i_hitSel[i]) begin
        o_ports = r_ports[i];
      end
    end
  end

endmodule

// File: rtl/output_port_lookup_six_ports.sv
// Two-stage output port lookup: stage A captures the beat and table hits, stage B holds
// the beat with the destination mask and PCP written into tuser.
module output_port_lookup_six_ports #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = tsn_switch_pkg::NUM_PORTS,
  parameter int NUM_ENTRIES        = 16,
  parameter int DEFAULT_PCP        = 0
) (
  input  logic                           axis_aclk,
  input  logic                           axis_reset,
  output_port_lookup_six_ports_if.slave  s_axis,
  output_port_lookup_six_ports_if.master m_axis,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0] cfg_addr,
  input  logic [47:0]                    cfg_mac,
  input  logic [NUM_PORTS-1:0]           cfg_ports,
  input  logic                           cfg_valid,
  output logic                           pkt_fwd,
  output logic                           pkt_drop
);
  import tsn_switch_pkg::*;

  localparam int KW = C_AXIS_DATA_WIDTH / 8;

  logic                          r_vA, r_vB, r_lastA, r_lastB, r_hdrB;
  logic [C_AXIS_DATA_WIDTH-1:0]  r_dataA, r_dataB;
  logic [KW-1:0]                 r_keepA, r_keepB;
  logic [C_AXIS_TUSER_WIDTH-1:0] r_userA, r_userB;
  logic [NUM_ENTRIES-1:0]        r_hitA;
  logic [1:0]                    r_state;
  logic                          r_pktFwd, r_pktDrop;

  logic                          w_rdyA, w_rdyB, w_xferA, w_loadB, w_isHdr, w_group, w_anyHit;
  logic [47:0]                   w_dmac;
  logic [15:0]                   w_etype;
  logic [PCP_W-1:0]              w_pcp;
  logic [NUM_ENTRIES-1:0]        w_hitVec;
  logic [NUM_PORTS-1:0]          w_tablePorts, w_src, w_mask;
  logic [C_AXIS_TUSER_WIDTH-1:0] w_userOut;
  logic [1:0]                    w_stateNext;

  assign w_rdyB        = ~r_vB | m_axis.tready;
  assign w_rdyA        = ~r_vA | w_rdyB;
  assign w_xferA       = r_vA & w_rdyB;
  assign s_axis.tready = w_rdyA;

  // Frame byte 0 is the most significant byte of the table's MAC representation.
  always_comb begin
    w_dmac = '0;
    for (int k = 0; k < 6; k++) begin
      w_dmac[47-8*k -: 8] = s_axis.tdata[8*(HDR_DMAC_BYTE+k) +: 8];
    end
  end

  mac_lookup_table #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .NUM_PORTS   (NUM_PORTS)
  ) u_table (
    .clk      (axis_aclk),
    .rst      (axis_reset),
    .i_wrEn   (cfg_wr_en),
    .i_addr   (cfg_addr),
    .i_mac    (cfg_mac),
    .i_ports  (cfg_ports),
    .i_valid  (cfg_valid),
    .i_dmac   (w_dmac),
    .o_hitVec (w_hitVec),
    .i_hitSel (r_hitA),
    .o_anyHit (w_anyHit),
    .o_ports  (w_tablePorts)
  );

  assign w_group = r_dataA[8*HDR_DMAC_BYTE];
  assign w_etype = {r_dataA[8*HDR_ETYPE_BYTE +: 8], r_dataA[8*(HDR_ETYPE_BYTE+1) +: 8]};
  assign w_pcp   = (w_etype == ETH_TYPE_VLAN) ? r_dataA[8*HDR_TCI_BYTE+5 +: PCP_W]
                                              : PCP_W'(DEFAULT_PCP);
  assign w_src   = r_userA[TUSER_SRC_LSB +: NUM_PORTS];
  assign w_mask  = ((w_group | ~w_anyHit) ? {NUM_PORTS{1'b1}} : w_tablePorts) & ~w_src;
  assign w_isHdr = (r_state == ST_HDR);
  assign w_loadB = w_xferA & ((w_isHdr & (|w_mask)) | (r_state == ST_BODY));

  always_comb begin
    w_userOut = r_userA;
    if (w_isHdr) begin
      w_userOut[TUSER_DST_LSB +: TUSER_PORT_W] = '0;
      w_userOut[TUSER_DST_LSB +: NUM_PORTS]    = w_mask;
      w_userOut[TUSER_PCP_LSB +: PCP_W]        = w_pcp;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    if (w_xferA) begin
      case (r_state)
        ST_HDR:  if (!r_lastA) w_stateNext = (|w_mask) ? ST_BODY : ST_DROP;
        ST_BODY: if (r_lastA)  w_stateNext = ST_HDR;
        ST_DROP: if (r_lastA)  w_stateNext = ST_HDR;
        default: w_stateNext = ST_HDR;
      endcase
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_vA    <= 1'b0;
      r_dataA <= '0;
      r_keepA <= '0;
      r_userA <= '0;
      r_lastA <= 1'b0;
      r_hitA  <= '0;
    end else if (w_rdyA) begin
      r_vA <= s_axis.tvalid;
      if (s_axis.tvalid) begin
        r_dataA <= s_axis.tdata;
        r_keepA <= s_axis.tkeep;
        r_userA <= s_axis.tuser;
        r_lastA <= s_axis.tlast;
        r_hitA  <= w_hitVec;
      end
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_vB    <= 1'b0;
      r_dataB <= '0;
      r_keepB <= '0;
      r_userB <= '0;
      r_lastB <= 1'b0;
      r_hdrB  <= 1'b0;
    end else if (w_rdyB) begin
      r_vB <= w_loadB;
      if (w_loadB) begin
        r_dataB <= r_dataA;
        r_keepB <= r_keepA;
        r_userB <= w_userOut;
        r_lastB <= r_lastA;
        r_hdrB  <= w_isHdr;
      end
    end
  end

  // Forward pulse follows the header leaving stage B; drop pulse follows the drop decision.
  always_ff @(posedge axis_aclk or posedge axis_reset) begin
    if (axis_reset) begin
      r_state   <= ST_HDR;
      r_pktFwd  <= 1'b0;
      r_pktDrop <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_pktFwd  <= r_vB & m_axis.tready & r_hdrB;
      r_pktDrop <= w_xferA & w_isHdr & ~(|w_mask);
    end
  end

  assign m_axis.tvalid = r_vB;
  assign m_axis.tdata  = r_dataB;
  assign m_axis.tkeep  = r_keepB;
  assign m_axis.tuser  = r_userB;
  assign m_axis.tlast  = r_lastB;
  assign pkt_fwd       = r_pktFwd;
  assign pkt_drop      = r_pktDrop;

endmodule

// File: tb/tb_output_port_lookup_six_ports.sv
// Scoreboard bench for output_port_lookup_six_ports: directed frames push expected beats,
// a negedge monitor pops and compares every m_axis transfer.
module tb_output_port_lookup_six_ports;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;

  localparam logic [47:0] MAC1  = 48'h00_11_22_33_44_55;
  localparam logic [47:0] MAC3  = 48'h00_AA_BB_CC_DD_EE;
  localparam logic [47:0] MACU  = 48'h02_00_00_00_00_99;
  localparam logic [47:0] MACBC = 48'hFF_FF_FF_FF_FF_FF;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic          hdr;
  } beat_t;

  logic axis_aclk = 1'b0;
  logic axis_reset;
  logic cfg_wr_en, cfg_valid;
  logic [3:0] cfg_addr;
  logic [47:0] cfg_mac;
  logic [5:0] cfg_ports;
  logic pkt_fwd, pkt_drop;

  output_port_lookup_six_ports_if #(.DATA_W(DW), .USER_W(UW)) sIf ();
  output_port_lookup_six_ports_if #(.DATA_W(DW), .USER_W(UW)) mIf ();

  output_port_lookup_six_ports dut (
    .axis_aclk  (axis_aclk),
    .axis_reset (axis_reset),
    .s_axis     (sIf),
    .m_axis     (mIf),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_addr   (cfg_addr),
    .cfg_mac    (cfg_mac),
    .cfg_ports  (cfg_ports),
    .cfg_valid  (cfg_valid),
    .pkt_fwd    (pkt_fwd),
    .pkt_drop   (pkt_drop)
  );

  always #5 axis_aclk = ~axis_aclk;

  beat_t expQ[$];
  int    checks = 0;
  int    errors = 0;
  int    fwdSeen = 0, dropSeen = 0, expFwd = 0, expDrop = 0;
  bit    randReady = 1'b0;
  bit    prevStall = 1'b0;
  bit    hdrPrev = 1'b0;
  beat_t stallSave;

  task automatic checkOutput(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: transfers are decided on the next posedge, inputs only change #1 after posedge.
  always @(negedge axis_aclk) begin
    if (axis_reset) begin
      prevStall = 1'b0;
      hdrPrev   = 1'b0;
    end else begin
      if (pkt_fwd || hdrPrev) checkOutput("pkt_fwd_timing", DW'(pkt_fwd), DW'(hdrPrev));
      if (pkt_fwd)  fwdSeen++;
      if (pkt_drop) dropSeen++;
      hdrPrev = 1'b0;
      if (prevStall) begin
        checkOutput("stall_tvalid", DW'(mIf.tvalid), DW'(1));
        checkOutput("stall_tdata", mIf.tdata, stallSave.data);
        checkOutput("stall_tuser", DW'(mIf.tuser), DW'(stallSave.user));
      end
      if (mIf.tvalid && mIf.tready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", DW'(1), DW'(0));
        end else begin
          beat_t e;
          e = expQ.pop_front();
          checkOutput("tdata", mIf.tdata, e.data);
          checkOutput("tkeep", DW'(mIf.tkeep), DW'(e.keep));
          checkOutput("tuser", DW'(mIf.tuser), DW'(e.user));
          checkOutput("tlast", DW'(mIf.tlast), DW'(e.last));
          hdrPrev = e.hdr;
        end
      end
      prevStall      = mIf.tvalid && !mIf.tready;
      stallSave.data = mIf.tdata;
      stallSave.user = mIf.tuser;
    end
  end

  initial begin
    mIf.tready = 1'b1;
    forever begin
      @(posedge axis_aclk);
      #1;
      mIf.tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic driveBeat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [UW-1:0] u, input logic l);
    int cyc = 0;
    sIf.tdata  = d;
    sIf.tkeep  = k;
    sIf.tuser  = u;
    sIf.tlast  = l;
    sIf.tvalid = 1'b1;
    forever begin
      @(negedge axis_aclk);
      if (sIf.tready) break;
      cyc++;
      if (cyc > 1000) begin
        checkOutput("s_tready_timeout", DW'(0), DW'(1));
        break;
      end
    end
    @(posedge axis_aclk);
    #1;
    sIf.tvalid = 1'b0;
  endtask

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  // One frame; expected beats are queued before the frame is driven.
  task automatic applyStimulus(input logic [47:0] dmac, input logic [7:0] src,
                               input logic [15:0] etype, input logic [15:0] tci,
                               input int nBeats, input logic [7:0] expDst,
                               input logic [2:0] expPcp, input bit expDropped, input bit gaps);
    beat_t b[$];
    for (int i = 0; i < nBeats; i++) begin
      beat_t x;
      x.data = randData();
      x.keep = (i == nBeats - 1) ? KW'($urandom) | KW'(1) : '1;
      x.user = {$urandom, $urandom, $urandom, $urandom};
      x.user[15:0]  = 16'(nBeats * 32);
      x.user[23:16] = src;
      x.last = (i == nBeats - 1);
      x.hdr  = (i == 0);
      if (i == 0) begin
        for (int k = 0; k < 6; k++) x.data[8*k +: 8] = dmac[47-8*k -: 8];
        x.data[48 +: 48] = 48'h0A_0B_0C_0D_0E_0F;
        x.data[96 +: 8]  = etype[15:8];
        x.data[104 +: 8] = etype[7:0];
        x.data[112 +: 8] = tci[15:8];
        x.data[120 +: 8] = tci[7:0];
      end
      b.push_back(x);
    end
    if (expDropped) begin
      expDrop++;
    end else begin
      expFwd++;
      for (int i = 0; i < nBeats; i++) begin
        beat_t e;
        e = b[i];
        if (i == 0) begin
          e.user[31:24] = expDst;
          e.user[34:32] = expPcp;
        end
        expQ.push_back(e);
      end
    end
    for (int i = 0; i < nBeats; i++) begin
      driveBeat(b[i].data, b[i].keep, b[i].user, b[i].last);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(posedge axis_aclk);
        #1;
      end
    end
  endtask

  task automatic cfgWrite(input logic [3:0] addr, input logic [47:0] mac,
                          input logic [5:0] ports, input logic v);
    cfg_wr_en = 1'b1;
    cfg_addr  = addr;
    cfg_mac   = mac;
    cfg_ports = ports;
    cfg_valid = v;
    @(posedge axis_aclk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 5000) begin
      @(posedge axis_aclk);
      n++;
    end
    if (expQ.size() != 0) checkOutput({name, "_drain_timeout"}, DW'(expQ.size()), DW'(0));
    repeat (4) @(posedge axis_aclk);
    #1;
    checkOutput({name, "_fwd_count"}, DW'(fwdSeen), DW'(expFwd));
    checkOutput({name, "_drop_count"}, DW'(dropSeen), DW'(expDrop));
  endtask

  function automatic logic [5:0] modelMask(input logic [47:0] dmac, input logic [7:0] src);
    logic [5:0] m;
    if (dmac == MAC1)      m = 6'b000100;
    else if (dmac == MAC3) m = 6'b001000;
    else                   m = 6'b111111;
    return m & ~src[5:0];
  endfunction

  initial begin
    sIf.tvalid = 1'b0;
    sIf.tdata  = '0;
    sIf.tkeep  = '0;
    sIf.tuser  = '0;
    sIf.tlast  = 1'b0;
    cfg_wr_en  = 1'b0;
    cfg_addr   = '0;
    cfg_mac    = '0;
    cfg_ports  = '0;
    cfg_valid  = 1'b0;
    axis_reset = 1'b0;
    #1 axis_reset = 1'b1;
    repeat (2) @(negedge axis_aclk);
    checkOutput("reset_m_tvalid", DW'(mIf.tvalid), DW'(0));
    checkOutput("reset_s_tready", DW'(sIf.tready), DW'(1));
    checkOutput("reset_pkt_fwd", DW'(pkt_fwd), DW'(0));
    axis_reset = 1'b0;
    @(posedge axis_aclk);
    #1;

    $display("[TB] test1 empty table flood");
    applyStimulus(MAC1, 8'h01, 16'h0800, 16'h0, 3, 8'h3E, 3'd0, 1'b0, 1'b0);
    drain("t1");

    $display("[TB] test2 table hit, lowest index wins");
    cfgWrite(4'd2, MAC1, 6'b000100, 1'b1);
    applyStimulus(MAC1, 8'h02, 16'h0800, 16'h0, 3, 8'h04, 3'd0, 1'b0, 1'b0);
    cfgWrite(4'd5, MAC1, 6'b001000, 1'b1);
    applyStimulus(MAC1, 8'h02, 16'h0800, 16'h0, 2, 8'h04, 3'd0, 1'b0, 1'b0);
    drain("t2");

    $display("[TB] test3 drop to source port then back-to-back forward");
    cfgWrite(4'd7, MAC3, 6'b001000, 1'b1);
    applyStimulus(MAC3, 8'h08, 16'h0800, 16'h0, 2, 8'h00, 3'd0, 1'b1, 1'b0);
    applyStimulus(MAC3, 8'h01, 16'h0800, 16'h0, 3, 8'h08, 3'd0, 1'b0, 1'b0);
    applyStimulus(MAC3, 8'h08, 16'h0800, 16'h0, 1, 8'h00, 3'd0, 1'b1, 1'b0);
    applyStimulus(MAC3, 8'h01, 16'h0800, 16'h0, 1, 8'h08, 3'd0, 1'b0, 1'b0);
    drain("t3");

    $display("[TB] test4 VLAN PCP and broadcast");
    applyStimulus(MACU, 8'h01, 16'h8100, 16'hA005, 2, 8'h3E, 3'b101, 1'b0, 1'b0);
    applyStimulus(MACU, 8'h01, 16'h0800, 16'hA005, 2, 8'h3E, 3'b000, 1'b0, 1'b0);
    applyStimulus(MACBC, 8'h04, 16'h0800, 16'h0, 2, 8'h3B, 3'b000, 1'b0, 1'b0);
    drain("t4");

    $display("[TB] test5 random backpressure, 200 frames");
    randReady = 1'b1;
    for (int f = 0; f < 200; f++) begin
      logic [47:0] dmac;
      logic [7:0]  src;
      logic [15:0] tci, etype;
      logic [5:0]  m;
      logic [2:0]  pcp;
      case ($urandom_range(0, 3))
        0:       dmac = MAC1;
        1:       dmac = MAC3;
        2:       dmac = MACU;
        default: dmac = MACBC;
      endcase
      src   = 8'(1 << $urandom_range(0, 5));
      tci   = 16'($urandom);
      etype = ($urandom_range(0, 1) == 1) ? 16'h8100 : 16'h86DD;
      pcp   = (etype == 16'h8100) ? tci[15:13] : 3'd0;
      m     = modelMask(dmac, src);
      applyStimulus(dmac, src, etype, tci, $urandom_range(1, 60), {2'b00, m}, pcp,
                    (m == 6'd0), 1'b1);
    end
    drain("t5");
    randReady = 1'b0;
    @(posedge axis_aclk);
    #1;

    $display("[TB] test6 reset mid-frame");
    begin
      logic [DW-1:0] d;
      logic [UW-1:0] u;
      d = randData();
      for (int k = 0; k < 6; k++) d[8*k +: 8] = MAC1[47-8*k -: 8];
      u = '0;
      u[23:16] = 8'h02;
      driveBeat(d, '1, u, 1'b0);
      driveBeat(randData(), '1, u, 1'b0);
      sIf.tdata  = randData();
      sIf.tvalid = 1'b1;
      #1 axis_reset = 1'b1;
      #1;
      checkOutput("midreset_m_tvalid", DW'(mIf.tvalid), DW'(0));
      checkOutput("midreset_pkt_fwd", DW'(pkt_fwd), DW'(0));
      sIf.tvalid = 1'b0;
      @(negedge axis_aclk);
      axis_reset = 1'b0;
      expQ.delete();
      fwdSeen  = 0;
      dropSeen = 0;
      expFwd   = 0;
      expDrop  = 0;
      @(posedge axis_aclk);
      #1;
    end
    applyStimulus(MAC1, 8'h02, 16'h0800, 16'h0, 3, 8'h3D, 3'd0, 1'b0, 1'b0);
    drain("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
